// File: rtl/calc_pkg.sv
// Shared constants for the calculator sequencer: key codes, FSM states and
// datapath limits used by the scheduler, its divider and its interface.
package calc_pkg;

  localparam int W_DEF         = 24;
  localparam int ENTRY_MAX_DEF = 100000;
  localparam int DISP_MAX      = 999999;

  localparam logic [3:0] KEY_BS  = 4'd10;
  localparam logic [3:0] KEY_CLR = 4'd11;
  localparam logic [3:0] KEY_ADD = 4'd12;
  localparam logic [3:0] KEY_SUB = 4'd13;
  localparam logic [3:0] KEY_MUL = 4'd14;
  localparam logic [3:0] KEY_DIV = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV_RUN,
    S_DIV_WB
  } state_t;

endpackage

// File: rtl/calc_op_sched_if.sv
// Key-event input and display/status output bundle of the calculator sequencer.
// master drives keys (keypad front end), slave is the sequencer.
interface calc_op_sched_if #(
  parameter int W = calc_pkg::W_DEF
) ();

  logic         key_valid;
  logic [3:0]   key_code;
  logic         busy;
  logic         done;
  logic [W-1:0] disp_bin;
  logic         disp_acc;
  logic         err_div0;
  logic         overrun;
  logic         ovf;

  modport master (
    output key_valid, key_code,
    input  busy, done, disp_bin, disp_acc, err_div0, overrun, ovf
  );

  modport slave (
    input  key_valid, key_code,
    output busy, done, disp_bin, disp_acc, err_div0, overrun, ovf
  );

endinterface

// File: rtl/calc_div_seq.sv
// Restoring unsigned divider: one quotient bit per clock, W clocks after start.
// done is high during the cycle whose closing edge shifts in the last bit.
module calc_div_seq #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         abort,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem_q, quo_q, dvs_q;
  logic [CW-1:0] cnt_q;
  logic          run_q;
  logic [W:0]    shifted;
  logic          ge;
  logic [W-1:0]  diff;

  assign shifted  = {rem_q, quo_q[W-1]};
  assign ge       = shifted >= {1'b0, dvs_q};
  assign diff     = shifted[W-1:0] - dvs_q;
  assign busy     = run_q;
  assign done     = run_q && (cnt_q == CW'(1));
  assign quotient = quo_q;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (start) begin
      run_q <= 1'b1;
      cnt_q <= CW'(W);
    end else if (run_q) begin
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == CW'(1)) run_q <= 1'b0;
    end
  end

  // NOTE: datapath registers carry no reset; start loads them before anything reads them.
  always_ff @(posedge clk) begin
    if (start) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (run_q) begin
      rem_q <= ge ? diff : shifted[W-1:0];
      quo_q <= {quo_q[W-2:0], ge};
    end
  end

endmodule

// File: rtl/calc_op_sched.sv
// Calculator sequencer: entry/accumulator registers, one-cycle add/sub/mul,
// iterative divide with a one-deep pending key. CALC_SAT_EN enables result clamping.
module calc_op_sched
  import calc_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter int ENTRY_MAX = ENTRY_MAX_DEF
) (
  input  logic           clk,
  input  logic           rst,
  calc_op_sched_if.slave bus
);

`ifdef CALC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif
  // Clamping needs head-room above W to see the true result; wrapping does not.
  localparam int RW = SAT_EN ? 2 * W : W;
  localparam logic signed [RW-1:0] SAT_HI = RW'(DISP_MAX);
  localparam logic signed [RW-1:0] SAT_LO = -SAT_HI;

  state_t          state_q, state_d;
  logic [W-1:0]    entry_q, entry_d, acc_q, acc_d, disp_q, disp_d;
  logic            dacc_q, dacc_d, err_q, err_d, ovr_q, ovr_d, ovf_q, ovf_d;
  logic            pend_v_q, pend_v_d, sign_q, sign_d, done_q, done_d;
  logic [3:0]      pend_q, pend_d, exec_k;
  logic            exec_v, do_clr, clr_busy, fit_hit, busy;
  logic            div_start, div_abort, div_busy, div_done;
  logic [W-1:0]    div_q, acc_mag;
  logic signed [RW-1:0] a_w, e_w, q_w, r_w;

  // Returns {clamped, value}; without saturation the low W bits are the wrapped result.
  function automatic logic [W:0] fit(input logic signed [RW-1:0] x);
    if (SAT_EN && x > SAT_HI) return {1'b1, SAT_HI[W-1:0]};
    if (SAT_EN && x < SAT_LO) return {1'b1, SAT_LO[W-1:0]};
    return {1'b0, x[W-1:0]};
  endfunction

  assign a_w     = RW'(signed'(acc_q));
  assign e_w     = signed'(RW'(entry_q));
  assign q_w     = signed'(RW'(div_q));
  assign acc_mag = acc_q[W-1] ? -acc_q : acc_q;
  assign busy    = div_busy || (state_q == S_DIV_WB);
  assign clr_busy = bus.key_valid && (bus.key_code == KEY_CLR) && busy;

  calc_div_seq #(.W(W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .abort    (div_abort),
    .start    (div_start),
    .dividend (acc_mag),
    .divisor  (entry_q),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

  // NOTE: every variable written here gets a default first, so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    entry_d   = entry_q;
    acc_d     = acc_q;
    disp_d    = disp_q;
    dacc_d    = dacc_q;
    err_d     = err_q;
    ovr_d     = ovr_q;
    ovf_d     = ovf_q;
    pend_v_d  = pend_v_q;
    pend_d    = pend_q;
    sign_d    = sign_q;
    done_d    = 1'b0;
    div_start = 1'b0;
    div_abort = 1'b0;
    exec_v    = 1'b0;
    exec_k    = '0;
    do_clr    = 1'b0;
    fit_hit   = 1'b0;
    r_w       = '0;

    unique case (state_q)
      S_IDLE: begin
        // The pending key drains first; a key arriving alongside refills the buffer.
        if (pend_v_q) begin
          exec_v   = 1'b1;
          exec_k   = pend_q;
          pend_v_d = bus.key_valid;
          pend_d   = bus.key_code;
        end else if (bus.key_valid) begin
          exec_v = 1'b1;
          exec_k = bus.key_code;
        end
      end
      S_DIV_RUN: if (div_done) state_d = S_DIV_WB;
      S_DIV_WB: begin
        r_w              = sign_q ? -q_w : q_w;
        {fit_hit, acc_d} = fit(r_w);
        ovf_d            = ovf_q | fit_hit;
        entry_d          = '0;
        disp_d           = acc_d;
        dacc_d           = 1'b1;
        done_d           = 1'b1;
        state_d          = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (busy && bus.key_valid) begin
      if (!pend_v_q) begin
        pend_v_d = 1'b1;
        pend_d   = bus.key_code;
      end else begin
        ovr_d = 1'b1;
      end
    end

    if (exec_v) begin
      if (exec_k <= 4'd9) begin
        if (entry_q < W'(ENTRY_MAX)) entry_d = entry_q * W'(10) + W'(exec_k);
        disp_d = entry_d;
        dacc_d = 1'b0;
      end else begin
        case (exec_k)
          KEY_BS: begin
            entry_d = entry_q / W'(10);
            disp_d  = entry_d;
            dacc_d  = 1'b0;
          end
          KEY_CLR: do_clr = 1'b1;
          KEY_ADD, KEY_SUB, KEY_MUL: begin
            case (exec_k)
              KEY_ADD: r_w = a_w + e_w;
              KEY_SUB: r_w = a_w - e_w;
              default: r_w = a_w * e_w;
            endcase
            {fit_hit, acc_d} = fit(r_w);
            ovf_d            = ovf_q | fit_hit;
            entry_d          = '0;
            disp_d           = acc_d;
            dacc_d           = 1'b1;
          end
          KEY_DIV: begin
            if (entry_q == '0) begin
              err_d  = 1'b1;
              disp_d = acc_q;
              dacc_d = 1'b1;
            end else begin
              div_start = 1'b1;
              sign_d    = acc_q[W-1];
              state_d   = S_DIV_RUN;
            end
          end
          default: ;
        endcase
      end
    end

    // Clear during a divide wins over write-back, capture and overrun.
    if (clr_busy) begin
      do_clr    = 1'b1;
      div_abort = 1'b1;
      state_d   = S_IDLE;
      pend_v_d  = 1'b0;
      done_d    = 1'b0;
    end
    if (do_clr) begin
      acc_d   = '0;
      entry_d = '0;
      err_d   = 1'b0;
      ovr_d   = 1'b0;
      ovf_d   = 1'b0;
      disp_d  = '0;
      dacc_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      entry_q  <= '0;
      acc_q    <= '0;
      disp_q   <= '0;
      dacc_q   <= 1'b0;
      err_q    <= 1'b0;
      ovr_q    <= 1'b0;
      ovf_q    <= 1'b0;
      pend_v_q <= 1'b0;
      pend_q   <= '0;
      sign_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      entry_q  <= entry_d;
      acc_q    <= acc_d;
      disp_q   <= disp_d;
      dacc_q   <= dacc_d;
      err_q    <= err_d;
      ovr_q    <= ovr_d;
      ovf_q    <= ovf_d;
      pend_v_q <= pend_v_d;
      pend_q   <= pend_d;
      sign_q   <= sign_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done_q;
  assign bus.disp_bin = disp_q;
  assign bus.disp_acc = dacc_q;
  assign bus.err_div0 = err_q;
  assign bus.overrun  = ovr_q;
  assign bus.ovf      = ovf_q;

endmodule
